// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if
//   Host-side bus of the nibble-serial add sequencer.
//   The host (switch or host logic, or the bench) uses the master modport.
//   The sequencer uses the slave modport.
//
//   Signals:
//     start  host -> seq   request; honoured only while the sequencer is idle
//     a, b   host -> seq   WIDTH-bit operands, captured on an accepted start
//     cin    host -> seq   carry into the least significant slice
//     sub    host -> seq   subtract select (present only with ADD_SUB_EN)
//     busy   seq -> host   high while slices are being processed
//     done   seq -> host   one-cycle completion pulse
//     s      seq -> host   registered sum
//     cout   seq -> host   registered carry-out of the most significant slice
//     v      seq -> host   registered two's-complement overflow
//
//   Optional feature macro: ADD_SUB_EN adds the sub signal.
interface add_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             v;

`ifdef ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, cout, v);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, v);
`else
    modport master (output start, a, b, cin, input busy, done, s, cout, v);
    modport slave  (input start, a, b, cin, output busy, done, s, cout, v);
`endif
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
//   Sequencer for one external 4-bit ripple-carry adder slice.
//   It adds WIDTH-bit operands one nibble per clock, starting with the least significant nibble.
//   The carry between slices is held in a register.
//   The wide sum, carry-out and overflow are assembled in registers.
//   FSM: IDLE -> RUN (WIDTH/4 cycles) -> DONE (one cycle) -> IDLE.
//
//   Ports:
//     clk_i        system clock; all logic runs on the rising edge
//     rst_i        synchronous, active-high reset
//     bus          add_seq_ctrl_if.slave; start/operands in, busy/done/results out
//     sliceA_o     nibble k of the captured operand A, to the adder
//     sliceB_o     nibble k of the captured effective operand B, to the adder
//     sliceCin_o   inter-slice carry register, to the adder
//     sliceS_i     adder sum (combinational, same cycle)
//     sliceCout_i  adder carry-out
//
//   Parameter: WIDTH is the operand width; it must be a multiple of 4 and at least 4.
//   Optional feature macro ADD_SUB_EN:
//     - bus.sub = 1 selects A - B.
//     - B is inverted and the initial carry is forced to 1; cin is ignored.
//     - cout = 1 then means no borrow.
module add_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    add_seq_ctrl_if.slave bus,
    output logic [3:0]    sliceA_o,
    output logic [3:0]    sliceB_o,
    output logic          sliceCin_o,
    input  logic [3:0]    sliceS_i,
    input  logic          sliceCout_i
);

    localparam int NSL = WIDTH / 4;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] aCap_q;
    logic [WIDTH-1:0] bCap_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             v_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] bEff_d;
    logic             cinEff_d;
    logic [WIDTH-1:0] aShift_d;
    logic [WIDTH-1:0] bShift_d;

    // Effective B operand and initial carry.
    // Subtraction is A + ~B + 1, so it reuses the same adder slice.
    always_comb begin
`ifdef ADD_SUB_EN
        bEff_d   = bus.sub ? ~bus.b : bus.b;
        cinEff_d = bus.sub ? 1'b1 : bus.cin;
`else
        bEff_d   = bus.b;
        cinEff_d = bus.cin;
`endif
    end

    // Present nibble k of the captured operands to the adder.
    // Shifting by 4*k avoids a variable part-select.
    always_comb begin
        aShift_d   = aCap_q >> {k_q, 2'b00};
        bShift_d   = bCap_q >> {k_q, 2'b00};
        sliceA_o   = aShift_d[3:0];
        sliceB_o   = bShift_d[3:0];
        sliceCin_o = carry_q;
    end

    // Control FSM and datapath registers.
    // Done is asserted on entry to DONE and is cleared by default on the following edge.
    // That makes it a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            aCap_q  <= '0;
            bCap_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        aCap_q  <= bus.a;
                        bCap_q  <= bEff_d;
                        carry_q <= cinEff_d;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSL; i++) begin
                        if (k_q == KW'(i)) begin
                            sum_q[4*i +: 4] <= sliceS_i;
                        end
                    end
                    carry_q <= sliceCout_i;
                    if (k_q == LAST_K) begin
                        // The final slice supplies the sum MSB, so overflow is decided from sliceS_i[3] here.
                        cout_q  <= sliceCout_i;
                        v_q     <= (aCap_q[WIDTH-1] == bCap_q[WIDTH-1]) &&
                                   (sliceS_i[3] != aCap_q[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = sum_q;
    assign bus.cout = cout_q;
    assign bus.v    = v_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl
//   Directed bench for add_seq_ctrl.
//   It has a 16-bit instance and a 4-bit instance.
//   Each instance is wired to a behavioural 4-bit adder slice model.
//   Subtract vectors run only when ADD_SUB_EN is defined.
module tb_add_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   nd;

    always #5 clk = ~clk;

    add_seq_ctrl_if #(.WIDTH(16)) bus16 ();
    add_seq_ctrl_if #(.WIDTH(4))  bus4 ();

    logic [3:0] sA16, sB16, sS16, sA4, sB4, sS4;
    logic       sCin16, sCout16, sCin4, sCout4;

    // Reference adder slices: {cout, sum} = a + b + cin
    assign {sCout16, sS16} = {1'b0, sA16} + {1'b0, sB16} + {4'b0000, sCin16};
    assign {sCout4, sS4}   = {1'b0, sA4} + {1'b0, sB4} + {4'b0000, sCin4};

    add_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus16),
        .sliceA_o    (sA16),
        .sliceB_o    (sB16),
        .sliceCin_o  (sCin16),
        .sliceS_i    (sS16),
        .sliceCout_i (sCout16)
    );

    add_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus4),
        .sliceA_o    (sA4),
        .sliceB_o    (sB4),
        .sliceCin_o  (sCin4),
        .sliceS_i    (sS4),
        .sliceCout_i (sCout4)
    );

    logic [15:0] expS3 [3] = '{16'h2011, 16'h2617, 16'h2C1D};

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Run one 16-bit operation from IDLE.
    // Checks the busy window (exactly four cycles), the done timing and the results.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic [15:0] expS,
                                 input logic expCout, input logic expV);
        bus16.a     = a;
        bus16.b     = b;
        bus16.cin   = cin;
`ifdef ADD_SUB_EN
        bus16.sub   = sub;
`else
        if (sub) $display("[TB] note: sub request ignored without ADD_SUB_EN");
`endif
        checkOutput({tag, "_idleBusy"}, {31'b0, bus16.busy}, 32'd0);
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checkOutput({tag, "_busy"}, {31'b0, bus16.busy}, 32'd1);
            checkOutput({tag, "_earlyDone"}, {31'b0, bus16.done}, 32'd0);
            tick();
        end
        checkOutput({tag, "_done"}, {31'b0, bus16.done}, 32'd1);
        checkOutput({tag, "_busyOff"}, {31'b0, bus16.busy}, 32'd0);
        checkOutput({tag, "_s"}, {16'b0, bus16.s}, {16'b0, expS});
        checkOutput({tag, "_cout"}, {31'b0, bus16.cout}, {31'b0, expCout});
        checkOutput({tag, "_v"}, {31'b0, bus16.v}, {31'b0, expV});
        tick();
        checkOutput({tag, "_donePulse"}, {31'b0, bus16.done}, 32'd0);
        checkOutput({tag, "_sHold"}, {16'b0, bus16.s}, {16'b0, expS});
    endtask

    initial begin
        rst         = 1'b1;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        bus16.cin   = 1'b0;
        bus4.start  = 1'b0;
        bus4.a      = '0;
        bus4.b      = '0;
        bus4.cin    = 1'b0;
`ifdef ADD_SUB_EN
        bus16.sub   = 1'b0;
        bus4.sub    = 1'b0;
`endif
        tick();
        tick();

        // Reset state of both instances
        checkOutput("rst_busy", {31'b0, bus16.busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus16.done}, 32'd0);
        checkOutput("rst_s", {16'b0, bus16.s}, 32'd0);
        checkOutput("rst_cout", {31'b0, bus16.cout}, 32'd0);
        checkOutput("rst_v", {31'b0, bus16.v}, 32'd0);
        checkOutput("rst_slices", {23'b0, sA16, sB16, sCin16}, 32'd0);
        checkOutput("rst4_s", {28'b0, bus4.s}, 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: plain add
        applyStimulus("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Test 2: carry-out, overflow, and carry-in boundaries
        applyStimulus("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("t2b", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus("t2c", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

        // Test 3: start held high; only operands present in IDLE cycles are accepted
        nd          = 0;
        bus16.cin   = 1'b0;
        bus16.start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            bus16.a = 16'h0011 + 16'(c * 256);
            bus16.b = 16'h2000 + 16'(c);
            tick();
            checkOutput("t3_donePhase", {31'b0, bus16.done}, (c % 6 == 4) ? 32'd1 : 32'd0);
            if (bus16.done && nd < 3) begin
                checkOutput("t3_sum", {16'b0, bus16.s}, {16'b0, expS3[nd]});
                nd++;
            end
        end
        bus16.start = 1'b0;
        checkOutput("t3_doneCount", nd, 32'd3);
        tick();

        // Test 4: reset two cycles into RUN aborts the operation
        bus16.a     = 16'h1234;
        bus16.b     = 16'h4321;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t4_busy", {31'b0, bus16.busy}, 32'd0);
        checkOutput("t4_done", {31'b0, bus16.done}, 32'd0);
        checkOutput("t4_s", {16'b0, bus16.s}, 32'd0);
        checkOutput("t4_cout", {31'b0, bus16.cout}, 32'd0);
        for (int j = 0; j < 5; j++) begin
            tick();
            checkOutput("t4_noDone", {31'b0, bus16.done}, 32'd0);
        end
        applyStimulus("t4b", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef ADD_SUB_EN
        // Test 5: subtract mode, then add mode again with the same operands as test 1
        applyStimulus("t5a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus("t5b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus("t5c", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
`endif

        // Test 6: WIDTH=4 instance, single RUN cycle
        bus4.a     = 4'h9;
        bus4.b     = 4'h8;
        bus4.cin   = 1'b1;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        checkOutput("t6_busy", {31'b0, bus4.busy}, 32'd1);
        checkOutput("t6_earlyDone", {31'b0, bus4.done}, 32'd0);
        tick();
        checkOutput("t6_done", {31'b0, bus4.done}, 32'd1);
        checkOutput("t6_busyOff", {31'b0, bus4.busy}, 32'd0);
        checkOutput("t6_s", {28'b0, bus4.s}, 32'h2);
        checkOutput("t6_cout", {31'b0, bus4.cout}, 32'd1);
        checkOutput("t6_v", {31'b0, bus4.v}, 32'd1);
        tick();
        checkOutput("t6_donePulse", {31'b0, bus4.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
